// File: rtl/stark_const_pfx_merge_pkg.sv
// Shared types and constants for the constant-prefix merge stage.
package stark_const_pfx_merge_pkg;

   localparam int unsigned MAXPFX = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HELD = 1'b1
   } pfx_state_e;

   typedef struct packed {
      logic [63:0] val;
      logic        has;
   } merged_imm_t;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/stark_pfx_slot.sv
// One prefix slot: held 32-bit upper value plus the merge mux that forms the 64-bit immediate.
module stark_pfx_slot
   import stark_const_pfx_merge_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic [31:0] imm_i,
   input  logic        has_i,
   output logic        held_o,
   output merged_imm_t merged_o
);

   logic        held_q;
   logic [31:0] val_q;

   // Held value/valid register; a clear always wins over a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= 1'b0;
         val_q  <= 32'h0000_0000;
      end else if (clr_i) begin
         held_q <= 1'b0;
         val_q  <= 32'h0000_0000;
      end else if (load_i) begin
         held_q <= 1'b1;
         val_q  <= imm_i;
      end else begin
         held_q <= held_q;
         val_q  <= val_q;
      end
   end

   // Merge mux: held prefix supplies the upper half, otherwise sign-extend.
   always_comb begin
      merged_o = '0;
      if (held_q) begin
         merged_o.val = {val_q, imm_i};
         merged_o.has = 1'b1;
      end else begin
         merged_o.val = sext32(imm_i);
         merged_o.has = has_i;
      end
   end

   assign held_o = held_q;

endmodule

// File: rtl/stark_const_pfx_merge.sv
// Absorbs constant-prefix instructions and merges their values into the next
// instruction's immediates, presented through a registered valid/ready output stage.
module stark_const_pfx_merge
   import stark_const_pfx_merge_pkg::*;
#(
   parameter int unsigned PCW = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush_i,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [PCW-1:0] in_pc,
   input  logic [31:0]    in_ins,
   input  logic [31:0]    in_imma,
   input  logic [31:0]    in_immb,
   input  logic [31:0]    in_immc,
   input  logic           in_has_imma,
   input  logic           in_has_immb,
   input  logic           in_has_immc,
   input  logic           in_pfxa,
   input  logic           in_pfxb,
   input  logic           in_pfxc,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PCW-1:0] out_pc,
   output logic [31:0]    out_ins,
   output logic [63:0]    out_imma,
   output logic [63:0]    out_immb,
   output logic [63:0]    out_immc,
   output logic           out_has_imma,
   output logic           out_has_immb,
   output logic           out_has_immc,
   output logic [1:0]     out_npfx,
   output logic           out_pfx_err
);

   pfx_state_e     state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           err_q, err_d;
   logic [PCW-1:0] grp_pc_q, grp_pc_d;

   logic           ov_q, ov_d;
   logic [PCW-1:0] opc_q, opc_d;
   logic [31:0]    oins_q, oins_d;
   merged_imm_t    oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
   logic [1:0]     onpfx_q, onpfx_d;
   logic           oerr_q, oerr_d;

   logic           in_ready_s, accept_s, is_pfx_s, pfx_xfer_s, ins_xfer_s, dup_s, slot_clr_s;
   logic           held_a_s, held_b_s, held_c_s;
   merged_imm_t    mrg_a_s, mrg_b_s, mrg_c_s;

   assign in_ready_s = !ov_q || out_ready;
   assign accept_s   = in_valid && in_ready_s && !flush_i;
   assign is_pfx_s   = in_pfxa || in_pfxb || in_pfxc;
   assign pfx_xfer_s = accept_s && is_pfx_s;
   assign ins_xfer_s = accept_s && !is_pfx_s;
   assign dup_s      = (in_pfxa && held_a_s) || (in_pfxb && held_b_s) || (in_pfxc && held_c_s);
   assign slot_clr_s = flush_i || ins_xfer_s;

   stark_pfx_slot u_slot_a (
      .clk(clk), .rst_n(rst_n), .clr_i(slot_clr_s), .load_i(pfx_xfer_s && in_pfxa),
      .imm_i(in_imma), .has_i(in_has_imma), .held_o(held_a_s), .merged_o(mrg_a_s)
   );
   stark_pfx_slot u_slot_b (
      .clk(clk), .rst_n(rst_n), .clr_i(slot_clr_s), .load_i(pfx_xfer_s && in_pfxb),
      .imm_i(in_immb), .has_i(in_has_immb), .held_o(held_b_s), .merged_o(mrg_b_s)
   );
   stark_pfx_slot u_slot_c (
      .clk(clk), .rst_n(rst_n), .clr_i(slot_clr_s), .load_i(pfx_xfer_s && in_pfxc),
      .imm_i(in_immc), .has_i(in_has_immc), .held_o(held_c_s), .merged_o(mrg_c_s)
   );

   // Group FSM, prefix count, group PC and sticky duplicate flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      grp_pc_d = grp_pc_q;
      case (state_q)
         IDLE: begin
            if (pfx_xfer_s) begin
               state_d  = HELD;
               grp_pc_d = in_pc;
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (flush_i || ins_xfer_s) begin
               state_d = IDLE;
            end else begin
               state_d = HELD;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush_i || ins_xfer_s) begin
         cnt_d = 2'd0;
         err_d = 1'b0;
      end else if (pfx_xfer_s) begin
         // A duplicate at full count keeps count at MAXPFX.
         if (cnt_q != 2'(MAXPFX)) begin
            cnt_d = cnt_q + 2'd1;
         end else begin
            cnt_d = cnt_q;
         end
         if (dup_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output stage next-state: load on a non-prefix transfer, drop on drain or flush.
   always_comb begin
      ov_d    = ov_q;
      opc_d   = opc_q;
      oins_d  = oins_q;
      oa_d    = oa_q;
      ob_d    = ob_q;
      oc_d    = oc_q;
      onpfx_d = onpfx_q;
      oerr_d  = oerr_q;
      if (flush_i) begin
         ov_d = 1'b0;
      end else if (ins_xfer_s) begin
         ov_d    = 1'b1;
         opc_d   = (state_q == HELD) ? grp_pc_q : in_pc;
         oins_d  = in_ins;
         oa_d    = mrg_a_s;
         ob_d    = mrg_b_s;
         oc_d    = mrg_c_s;
         onpfx_d = cnt_q;
         oerr_d  = err_q;
      end else if (out_ready) begin
         ov_d = 1'b0;
      end else begin
         ov_d = ov_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         err_q    <= 1'b0;
         grp_pc_q <= '0;
         ov_q     <= 1'b0;
         opc_q    <= '0;
         oins_q   <= 32'h0000_0000;
         oa_q     <= '0;
         ob_q     <= '0;
         oc_q     <= '0;
         onpfx_q  <= 2'd0;
         oerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         grp_pc_q <= grp_pc_d;
         ov_q     <= ov_d;
         opc_q    <= opc_d;
         oins_q   <= oins_d;
         oa_q     <= oa_d;
         ob_q     <= ob_d;
         oc_q     <= oc_d;
         onpfx_q  <= onpfx_d;
         oerr_q   <= oerr_d;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = ov_q;
   assign out_pc       = opc_q;
   assign out_ins      = oins_q;
   assign out_imma     = oa_q.val;
   assign out_immb     = ob_q.val;
   assign out_immc     = oc_q.val;
   assign out_has_imma = oa_q.has;
   assign out_has_immb = ob_q.has;
   assign out_has_immc = oc_q.has;
   assign out_npfx     = onpfx_q;
   assign out_pfx_err  = oerr_q;

endmodule

// File: tb/tb_stark_const_pfx_merge.sv
// Directed bench for the constant-prefix merge stage with hand-computed expectations.
module tb_stark_const_pfx_merge;

   logic        clk = 1'b0;
   logic        rst_n, flush_i, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_ins, in_imma, in_immb, in_immc;
   logic        in_has_imma, in_has_immb, in_has_immc, in_pfxa, in_pfxb, in_pfxc;
   logic [31:0] out_pc, out_ins;
   logic [63:0] out_imma, out_immb, out_immc;
   logic        out_has_imma, out_has_immb, out_has_immc, out_pfx_err;
   logic [1:0]  out_npfx;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   stark_const_pfx_merge #(.PCW(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ins(in_ins), .in_imma(in_imma), .in_immb(in_immb), .in_immc(in_immc),
      .in_has_imma(in_has_imma), .in_has_immb(in_has_immb), .in_has_immc(in_has_immc),
      .in_pfxa(in_pfxa), .in_pfxb(in_pfxb), .in_pfxc(in_pfxc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
      .out_imma(out_imma), .out_immb(out_immb), .out_immc(out_immc),
      .out_has_imma(out_has_imma), .out_has_immb(out_has_immb), .out_has_immc(out_has_immc),
      .out_npfx(out_npfx), .out_pfx_err(out_pfx_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic setin(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                        input logic [2:0] has, input logic [2:0] pfx);
      in_pc = pc; in_ins = ins;
      in_imma = ia; in_immb = ib; in_immc = ic;
      {in_has_imma, in_has_immb, in_has_immc} = has;
      {in_pfxa, in_pfxb, in_pfxc} = pfx;
   endtask

   // Hold in_valid until one transfer happens (bounded), then drop it.
   task automatic xfer(input string tag);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      do begin
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 20);
      in_valid = 1'b0;
      chk({tag, "_accepted"}, {63'd0, ok}, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      setin(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_pc", {32'd0, out_pc}, 64'd0);
      chk("rst_imma", out_imma, 64'd0);
      chk("rst_npfx", {62'd0, out_npfx}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // No prefix: sign-extended immediate
      setin(32'h200, 32'h0000_00AD, 32'h0, 32'hFFFF_FFF0, 32'h0, 3'b010, 3'b000);
      xfer("noprefix");
      chk("np_valid", {63'd0, out_valid}, 64'd1);
      chk("np_immb", out_immb, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("np_hasb", {63'd0, out_has_immb}, 64'd1);
      chk("np_hasa", {63'd0, out_has_imma}, 64'd0);
      chk("np_npfx", {62'd0, out_npfx}, 64'd0);
      chk("np_pc", {32'd0, out_pc}, 64'h200);
      chk("np_ins", {32'd0, out_ins}, 64'hAD);

      // pfxb then LOAD
      setin(32'h100, 32'h0000_0B00, 32'h0, 32'h1234_5600, 32'h0, 3'b010, 3'b010);
      xfer("pfxb");
      chk("pfxb_noout", {63'd0, out_valid}, 64'd0);
      setin(32'h104, 32'h0000_0100, 32'h0, 32'h0000_0010, 32'h0, 3'b010, 3'b000);
      xfer("load");
      chk("ld_valid", {63'd0, out_valid}, 64'd1);
      chk("ld_immb", out_immb, 64'h1234_5600_0000_0010);
      chk("ld_npfx", {62'd0, out_npfx}, 64'd1);
      chk("ld_pc", {32'd0, out_pc}, 64'h100);
      chk("ld_ins", {32'd0, out_ins}, 64'h100);
      @(posedge clk); #1;
      chk("ld_single", {63'd0, out_valid}, 64'd0);

      // Three prefixes then STOREI
      setin(32'h120, 32'h0, 32'h1, 32'h0, 32'h0, 3'b100, 3'b100); xfer("pa");
      setin(32'h124, 32'h0, 32'h0, 32'h2, 32'h0, 3'b010, 3'b010); xfer("pb");
      setin(32'h128, 32'h0, 32'h0, 32'h0, 32'h3, 3'b001, 3'b001); xfer("pc");
      setin(32'h12C, 32'h0000_0510, 32'h10, 32'h20, 32'h30, 3'b000, 3'b000); xfer("storei");
      chk("st_imma", out_imma, 64'h0000_0001_0000_0010);
      chk("st_immb", out_immb, 64'h0000_0002_0000_0020);
      chk("st_immc", out_immc, 64'h0000_0003_0000_0030);
      chk("st_has", {61'd0, out_has_imma, out_has_immb, out_has_immc}, 64'd7);
      chk("st_npfx", {62'd0, out_npfx}, 64'd3);
      chk("st_err", {63'd0, out_pfx_err}, 64'd0);
      chk("st_pc", {32'd0, out_pc}, 64'h120);

      // Duplicate slot
      setin(32'h140, 32'h0, 32'h0, 32'h5, 32'h0, 3'b010, 3'b010); xfer("dup1");
      setin(32'h144, 32'h0, 32'h0, 32'h7, 32'h0, 3'b010, 3'b010); xfer("dup2");
      setin(32'h148, 32'h0000_00AD, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000); xfer("dupadd");
      chk("dup_immb", out_immb, 64'h0000_0007_0000_0000);
      chk("dup_err", {63'd0, out_pfx_err}, 64'd1);
      chk("dup_npfx", {62'd0, out_npfx}, 64'd2);
      setin(32'h150, 32'h0000_00AD, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000); xfer("nextgrp");
      chk("next_err", {63'd0, out_pfx_err}, 64'd0);
      chk("next_npfx", {62'd0, out_npfx}, 64'd0);

      // Saturation: fourth prefix duplicates slot C
      setin(32'h160, 32'h0, 32'h1, 32'h0, 32'h0, 3'b100, 3'b100); xfer("s1");
      setin(32'h164, 32'h0, 32'h0, 32'h2, 32'h0, 3'b010, 3'b010); xfer("s2");
      setin(32'h168, 32'h0, 32'h0, 32'h0, 32'h3, 3'b001, 3'b001); xfer("s3");
      setin(32'h16C, 32'h0, 32'h0, 32'h0, 32'h9, 3'b001, 3'b001); xfer("s4");
      setin(32'h170, 32'h0000_00AD, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000); xfer("sadd");
      chk("sat_npfx", {62'd0, out_npfx}, 64'd3);
      chk("sat_err", {63'd0, out_pfx_err}, 64'd1);
      chk("sat_immc", out_immc, 64'h0000_0009_0000_0000);
      @(posedge clk); #1;

      // Prefix offered while output stalls must not be absorbed
      out_ready = 1'b0;
      setin(32'h500, 32'h0000_00AD, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000); xfer("stall_add");
      setin(32'h504, 32'h0, 32'h99, 32'h0, 32'h0, 3'b100, 3'b100);
      in_valid = 1'b1;
      repeat (2) begin
         chk("stallpfx_ready", {63'd0, in_ready}, 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      setin(32'h508, 32'h0000_00AD, 32'h1, 32'h0, 32'h0, 3'b100, 3'b000); xfer("post_stall");
      chk("ps_imma", out_imma, 64'h1);
      chk("ps_npfx", {62'd0, out_npfx}, 64'd0);
      @(posedge clk); #1;

      // Backpressure: three back-to-back inputs, four stalled cycles
      out_ready = 1'b0;
      setin(32'h600, 32'h0000_00A1, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000); xfer("bp1");
      setin(32'h604, 32'h0000_00A2, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_hold_ins", {32'd0, out_ins}, 64'hA1);
         chk("bp_hold_pc", {32'd0, out_pc}, 64'h600);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_second", {32'd0, out_ins}, 64'hA2);
      chk("bp_second_v", {63'd0, out_valid}, 64'd1);
      setin(32'h608, 32'h0000_00A3, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_third", {32'd0, out_ins}, 64'hA3);
      chk("bp_third_pc", {32'd0, out_pc}, 64'h608);
      @(posedge clk); #1;
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Flush after a held prefix drops it and the same-cycle input
      setin(32'h300, 32'h0, 32'hAA, 32'h0, 32'h0, 3'b100, 3'b100); xfer("fl_pfx");
      setin(32'h304, 32'h0000_00AD, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      flush_i = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; in_valid = 1'b0;
      chk("fl_dropped", {63'd0, out_valid}, 64'd0);
      setin(32'h310, 32'h0000_00AD, 32'h5, 32'h0, 32'h0, 3'b100, 3'b000); xfer("fl_add");
      chk("fl_imma", out_imma, 64'h5);
      chk("fl_npfx", {62'd0, out_npfx}, 64'd0);
      chk("fl_pc", {32'd0, out_pc}, 64'h310);
      // Flush also clears a stalled output
      out_ready = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; out_ready = 1'b1;
      chk("fl_outclr", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset mid-group
      setin(32'h400, 32'h0000_00AD, 32'h44, 32'h0, 32'h0, 3'b100, 3'b000); xfer("r_add");
      setin(32'h404, 32'h0, 32'h77, 32'h0, 32'h0, 3'b100, 3'b100); xfer("r_pfx");
      #2; rst_n = 1'b0;
      #1;
      chk("ar_pc", {32'd0, out_pc}, 64'd0);
      chk("ar_imma", out_imma, 64'd0);
      chk("ar_hasa", {63'd0, out_has_imma}, 64'd0);
      chk("ar_ins", {32'd0, out_ins}, 64'd0);
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      setin(32'h410, 32'h0000_00AD, 32'h2, 32'h0, 32'h0, 3'b100, 3'b000); xfer("ar_add");
      chk("ar_after_imma", out_imma, 64'h2);
      chk("ar_after_npfx", {62'd0, out_npfx}, 64'd0);
      chk("ar_after_pc", {32'd0, out_pc}, 64'h410);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
